mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter LOAD_OP, default 7'b0000011, meaning the load opcode.
REQ-002 SHALL have parameter STORE_OP, default 7'b0100011, meaning the store opcode.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 mem_wd_i  in  5  destination register from the EX/MEM register.
REQ-007 mem_wreg_i  in  1  write-enable from the EX/MEM register.
REQ-008 mem_wdata_i  in  32  ALU result, or store data for stores.
REQ-009 mem_opcode_i  in  7  instruction opcode.
REQ-010 mem_funct3_i  in  3  access width and sign selector.
REQ-011 mem_mem_addr_i  in  32  effective byte address.
REQ-012 ram_addr_o  out  32  byte address to RAM.
REQ-013 ram_dout_o  out  8  write byte to RAM.
REQ-014 ram_din_i  in  8  read byte, valid one cycle after its address is presented.
REQ-015 ram_we_o  out  1  RAM write strobe.
REQ-016 stall_req_o  out  1  pipeline stall request.
REQ-017 wb_wd_o  out  5  destination register to MEM/WB.
REQ-018 wb_wreg_o  out  1  write-enable to MEM/WB.
REQ-019 wb_wdata_o  out  32  writeback data to MEM/WB.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DONE, plus a 3-bit byte counter cnt.
REQ-021 SHALL treat as legal: loads with funct3 000/001/010/100/101 (LB/LH/LW/LBU/LHU, N=1/2/4/1/2 bytes) and stores with funct3 000/001/010 (SB/SH/SW, N=1/2/4).
REQ-022 SHALL handle non-memory opcodes combinationally in the same cycle: wb_* equal inputs, stall_req_o=0, ram_we_o=0, ram_addr_o=0.
REQ-023 SHALL treat illegal-funct3 loads/stores as no access, no stall, wb_wreg_o=0.
REQ-024 IDLE with a legal access: stall_req_o=1, no RAM access, next state ACCESS, cnt=0.
REQ-025 Store in ACCESS, cnt<N: ram_addr_o=addr+cnt (mod 2^32), ram_dout_o=byte cnt of mem_wdata_i (little-endian), ram_we_o=1, cnt++; after cnt=N-1, go to DONE.
REQ-026 Load in ACCESS, cnt<N: ram_addr_o=addr+cnt, ram_we_o=0.
REQ-027 Load in ACCESS, cnt>=1: ram_din_i is captured into byte cnt-1 of an internal buffer; after the cnt=N cycle, go to DONE.
REQ-028 In ACCESS, stall_req_o SHALL be 1.
REQ-029 DONE: stall_req_o=0, ram_we_o=0; wb_wd_o=mem_wd_i, wb_wreg_o=mem_wreg_i for loads and 0 for stores.
REQ-030 DONE, load: wb_wdata_o = buffer, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-031 DONE, store: wb_wdata_o=0.
REQ-032 DONE SHALL always return to IDLE without re-examining the inputs, so the held instruction is not re-executed.
REQ-033 Total stalled cycles SHALL be N+2 for a load and N+1 for a store (IDLE detect cycle + ACCESS cycles); DONE is the single non-stalled result cycle.
REQ-034 Inputs SHALL be sampled live each cycle; the upstream stall holds them stable while stall_req_o=1.
REQ-035 Outside ACCESS, ram_addr_o=0, ram_dout_o=0, ram_we_o=0.

Reset
REQ-036 rst=0 SHALL asynchronously force state IDLE, cnt=0 and buffer=0, clearing any access in progress; no partial result is output.
REQ-037 While rst=0, ram_we_o=0, stall_req_o=0 and wb_wreg_o=0.

Verification
REQ-038 LW, addr 0x100, RAM 0x100..0x103 = 78,56,34,12 -> stall_req_o high 6 cycles; DONE gives wb_wdata_o=0x12345678, wb_wreg_o=1.
REQ-039 LB / LBU at a byte holding 0x80 -> wb_wdata_o=0xFFFFFF80 / 0x00000080.
REQ-040 SH, addr 0x200, data 0xDEADBEEF -> writes 0xEF@0x200, 0xBE@0x201, 0x202 untouched, stall high 3 cycles, wb_wreg_o=0.
REQ-041 LH, addr 0xFFFFFFFF -> ram_addr_o sequence 0xFFFFFFFF, 0x00000000 (wrap-around).
REQ-042 rst pulsed low during ACCESS of an SW after 2 bytes -> ram_we_o drops immediately, state IDLE, no further writes.
REQ-043 ADD-type opcode with mem_wdata_i=0x55 -> wb_wdata_o=0x55 in the same cycle, stall_req_o=0.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: byte-wide RAM bus between the memory stage and its data RAM.
interface mem_access_if;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;
  logic        ram_we_o;
  modport master (output ram_addr_o, ram_dout_o, ram_we_o, input ram_din_i);
  modport slave  (input ram_addr_o, ram_dout_o, ram_we_o, output ram_din_i);
endinterface

// File: rtl/mem_access.sv
// mem_access: pipeline memory stage, serialising loads/stores over a byte-wide RAM.
module mem_access #(
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [6:0]  mem_opcode_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [31:0] mem_mem_addr_i,
  mem_access_if.master ram,
  output logic        stall_req_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [2:0] cnt, n;
  logic [1:0] idx;
  logic [31:0] rbuf, ld_val;
  logic is_load, is_store, mem_op, acc, act;
  assign is_load  = mem_opcode_i == LOAD_OP;
  assign is_store = mem_opcode_i == STORE_OP;
  assign mem_op   = is_load || is_store;
  assign acc      = (is_load && (mem_funct3_i[2] ? !mem_funct3_i[1] : mem_funct3_i[1:0] != 2'b11))
                 || (is_store && !mem_funct3_i[2] && mem_funct3_i[1:0] != 2'b11);
  assign n        = mem_funct3_i[1] ? 3'd4 : mem_funct3_i[0] ? 3'd2 : 3'd1;
  assign idx      = cnt[1:0] - 2'd1;
  assign act      = state == ACCESS && cnt < n;
  // Read data lags its address by one cycle, so byte cnt-1 lands while cnt is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rbuf  <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          state <= ACCESS;
          cnt   <= '0;
          rbuf  <= '0;
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (is_load && cnt != 3'd0) rbuf[{idx, 3'b000} +: 8] <= ram.ram_din_i;
          if (is_load ? cnt == n : cnt == n - 3'd1) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign ld_val = mem_funct3_i == 3'b000 ? {{24{rbuf[7]}}, rbuf[7:0]}
                : mem_funct3_i == 3'b001 ? {{16{rbuf[15]}}, rbuf[15:0]}
                : mem_funct3_i == 3'b100 ? {24'd0, rbuf[7:0]}
                : mem_funct3_i == 3'b101 ? {16'd0, rbuf[15:0]}
                : rbuf;
  assign ram.ram_addr_o = act ? mem_mem_addr_i + {29'd0, cnt} : '0;
  assign ram.ram_dout_o = act && is_store ? mem_wdata_i[{cnt[1:0], 3'b000} +: 8] : '0;
  assign ram.ram_we_o   = rst && act && is_store;
  assign stall_req_o    = rst && (state == ACCESS || (state == IDLE && acc));
  assign wb_wd_o        = mem_wd_i;
  assign wb_wreg_o      = rst && (state == DONE ? is_load && mem_wreg_i
                                                : state == IDLE && !mem_op && mem_wreg_i);
  assign wb_wdata_o     = state == DONE ? (is_load ? ld_val : '0)
                        : state == IDLE && !mem_op ? mem_wdata_i : '0;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a transaction-level model.
module tb_mem_access;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] NOP   = 7'b0010011;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] mem_wd;
  logic mem_wreg;
  logic [31:0] mem_wdata, mem_addr, wb_wdata;
  logic [6:0] mem_opcode;
  logic [2:0] mem_funct3;
  logic stall_req, wb_wreg;
  logic [4:0] wb_wd;
  int n_vec = 0, n_err = 0;
  mem_access_if bus();
  mem_access dut (
    .clk(clk), .rst(rst), .mem_wd_i(mem_wd), .mem_wreg_i(mem_wreg), .mem_wdata_i(mem_wdata),
    .mem_opcode_i(mem_opcode), .mem_funct3_i(mem_funct3), .mem_mem_addr_i(mem_addr), .ram(bus),
    .stall_req_o(stall_req), .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] ^ {6'd0, a[9:8]} ^ 8'h5A;
  endfunction
  // Synchronous-read RAM, 1 KiB window; unwritten bytes read a fixed address pattern.
  bit [7:0] ram [1024];
  bit wv [1024];
  always @(posedge clk) begin
    if (bus.ram_we_o) begin
      ram[bus.ram_addr_o[9:0]] <= bus.ram_dout_o;
      wv[bus.ram_addr_o[9:0]]  <= 1'b1;
    end
    bus.ram_din_i <= wv[bus.ram_addr_o[9:0]] ? ram[bus.ram_addr_o[9:0]] : pat(bus.ram_addr_o);
  end
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return wv[a[9:0]] ? ram[a[9:0]] : pat(a);
  endfunction
  logic [7:0] refm [logic [31:0]];
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : pat(a);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, d,
                       input logic [4:0] wd, input logic wr);
    mem_opcode = op; mem_funct3 = f3; mem_addr = a; mem_wdata = d; mem_wd = wd; mem_wreg = wr;
  endtask
  task automatic next_op;
    @(posedge clk);
    #1 drive(NOP, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask
  task automatic do_mem(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, d,
                        input logic [4:0] wd, input logic wr, output logic [31:0] got);
    int n, st;
    logic ld;
    logic [31:0] v;
    ld = op == LOAD;
    n = f3[1:0] == 2'd2 ? 4 : f3[1:0] == 2'd1 ? 2 : 1;
    drive(op, f3, a, d, wd, wr);
    st = 0;
    @(negedge clk);
    while (stall_req && st < 16) begin
      chk("ram_we", 32'(bus.ram_we_o), (!ld && st >= 1) ? 32'd1 : 32'd0);
      if (st >= 1 && st <= n) begin
        chk("ram_addr", bus.ram_addr_o, a + 32'(st - 1));
        if (!ld) chk("ram_dout", 32'(bus.ram_dout_o), (d >> (8 * (st - 1))) & 32'hFF);
      end
      st++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(st), 32'(ld ? n + 2 : n + 1));
    chk("done_we", 32'(bus.ram_we_o), 32'd0);
    chk("wb_wd", 32'(wb_wd), 32'(wd));
    if (ld) begin
      v = 0;
      for (int i = 0; i < n; i++) v |= 32'(ref_rd(a + 32'(i))) << (8 * i);
      if (!f3[2] && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
      chk("ld_data", wb_wdata, v);
      chk("ld_wreg", 32'(wb_wreg), 32'(wr));
    end else begin
      for (int i = 0; i < n; i++) refm[a + 32'(i)] = d[8 * i +: 8];
      chk("st_data", wb_wdata, 32'd0);
      chk("st_wreg", 32'(wb_wreg), 32'd0);
      for (int i = 0; i < 4; i++) chk("ram_byte", 32'(ram_rd(a + 32'(i))), 32'(ref_rd(a + 32'(i))));
    end
    got = wb_wdata;
    next_op();
  endtask
  task automatic do_alu(input logic [6:0] op, input logic [31:0] d, input logic [4:0] wd, input logic wr);
    drive(op, 3'($urandom), 32'($urandom), d, wd, wr);
    @(negedge clk);
    chk("alu_data", wb_wdata, d);
    chk("alu_wd", 32'(wb_wd), 32'(wd));
    chk("alu_wreg", 32'(wb_wreg), 32'(wr));
    chk("alu_stall", 32'(stall_req), 32'd0);
    chk("alu_we", 32'(bus.ram_we_o), 32'd0);
    chk("alu_addr", bus.ram_addr_o, 32'd0);
    next_op();
  endtask
  task automatic do_bad(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, d);
    drive(op, f3, a, d, 5'd7, 1'b1);
    @(negedge clk);
    chk("bad_stall", 32'(stall_req), 32'd0);
    chk("bad_wreg", 32'(wb_wreg), 32'd0);
    chk("bad_we", 32'(bus.ram_we_o), 32'd0);
    chk("bad_addr", bus.ram_addr_o, 32'd0);
    next_op();
  endtask
  function automatic logic [31:0] pick_addr();
    int r = $urandom_range(0, 3);
    return r == 0 ? 32'hFFFF_FFFC + 32'($urandom_range(0, 9)) : 32'h100 + 32'($urandom_range(0, 63));
  endfunction
  initial begin
    logic [31:0] got, a;
    logic [2:0] f3;
    int r;
    drive(LOAD, 3'b010, 32'h100, 32'd0, 5'd3, 1'b1);
    #1 rst = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_we", 32'(bus.ram_we_o), 32'd0);
    chk("rst_wreg", 32'(wb_wreg), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_stall_clk", 32'(stall_req), 32'd0);
    drive(NOP, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_mem(STORE, 3'b000, 32'h100, 32'h78, 5'd0, 1'b0, got);
    do_mem(STORE, 3'b000, 32'h101, 32'h56, 5'd0, 1'b0, got);
    do_mem(STORE, 3'b000, 32'h102, 32'h34, 5'd0, 1'b0, got);
    do_mem(STORE, 3'b000, 32'h103, 32'h12, 5'd0, 1'b0, got);
    do_mem(LOAD, 3'b010, 32'h100, 32'd0, 5'd5, 1'b1, got);
    chk("lw_word", got, 32'h1234_5678);
    do_mem(STORE, 3'b000, 32'h110, 32'h80, 5'd0, 1'b0, got);
    do_mem(LOAD, 3'b000, 32'h110, 32'd0, 5'd6, 1'b1, got);
    chk("lb_sign", got, 32'hFFFF_FF80);
    do_mem(LOAD, 3'b100, 32'h110, 32'd0, 5'd6, 1'b1, got);
    chk("lbu_zero", got, 32'h0000_0080);
    do_mem(STORE, 3'b001, 32'h200, 32'hDEAD_BEEF, 5'd0, 1'b0, got);
    chk("sh_0x200", 32'(ram_rd(32'h200)), 32'hEF);
    chk("sh_0x201", 32'(ram_rd(32'h201)), 32'hBE);
    do_mem(LOAD, 3'b001, 32'hFFFF_FFFF, 32'd0, 5'd9, 1'b1, got);
    // Interrupt an SW once two bytes are written; the rest must never reach RAM.
    drive(STORE, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("sw_we_before_rst", 32'(bus.ram_we_o), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_we", 32'(bus.ram_we_o), 32'd0);
    chk("rst_mid_stall", 32'(stall_req), 32'd0);
    chk("rst_mid_wreg", 32'(wb_wreg), 32'd0);
    drive(NOP, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    refm[32'h300] = 8'h0D;
    refm[32'h301] = 8'hF0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_we", 32'(bus.ram_we_o), 32'd0);
      chk("post_rst_stall", 32'(stall_req), 32'd0);
    end
    for (int i = 0; i < 4; i++) chk("rst_sw_byte", 32'(ram_rd(32'h300 + 32'(i))), 32'(ref_rd(32'h300 + 32'(i))));
    @(posedge clk);
    #1;
    do_alu(7'b0110011, 32'h55, 5'd4, 1'b1);
    do_bad(LOAD, 3'b011, 32'h104, 32'd0);
    do_bad(STORE, 3'b100, 32'h104, 32'h1234);
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      a = pick_addr();
      if (r < 4) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        do_mem(LOAD, f3, a, 32'($urandom), 5'($urandom), 1'($urandom), got);
      end else if (r < 7) begin
        do_mem(STORE, 3'($urandom_range(0, 2)), a, 32'($urandom), 5'($urandom), 1'($urandom), got);
      end else if (r < 9) begin
        do_alu(r == 7 ? 7'b0110011 : 7'b0110111, 32'($urandom), 5'($urandom), 1'($urandom));
      end else if ($urandom_range(0, 1) == 0) begin
        f3 = 3'($urandom_range(0, 2));
        do_bad(LOAD, f3 == 0 ? 3'b011 : f3 == 1 ? 3'b110 : 3'b111, a, 32'($urandom));
      end else begin
        do_bad(STORE, 3'($urandom_range(3, 7)), a, 32'($urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
